// File: rtl/sparc_tlu_priv_pkg.sv
// rtl/sparc_tlu_priv_pkg.sv - shared sizes, types and FSM encoding for the TLU privilege block
// Optional feature macro used by this slice: TLU_PRIV_WR_CHK_EN.
package sparc_tlu_priv_pkg;

  localparam int NUM_THR = 4;
  localparam int MAXTL   = 6;
  localparam int TLW     = 3;

  typedef logic [1:0]     thr_id_t;
  typedef logic [TLW-1:0] tl_t;

  localparam tl_t MAX_TL = tl_t'(MAXTL);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } trap_fsm_e;

endpackage

// File: rtl/sparc_tlu_priv_thr.sv
// rtl/sparc_tlu_priv_thr.sv - per-thread PRIV, trap level, save stack and RED flag
// Priority between same-cycle strobes is resolved here: trap > done > wrpr.
module sparc_tlu_priv_thr
  import sparc_tlu_priv_pkg::*;
(
  input  logic rclk,
  input  logic reset,
  input  logic trap_go,
  input  logic done_go,
  input  logic wr_go,
  input  logic wr_priv,
  output logic priv,
  output tl_t  tl,
  output logic red
);

  logic [MAXTL-1:0] stack;
  tl_t              tl_dec;

  assign tl_dec = tl - tl_t'(1);

  always_ff @(posedge rclk) begin
    if (reset) begin
      priv  <= 1'b1;
      tl    <= '0;
      red   <= 1'b0;
      stack <= '0;
    end else if (trap_go) begin
      priv <= 1'b1;
      // A trap at MAXTL has nowhere to save state, so it only enters RED.
      if (tl < MAX_TL) begin
        stack[tl] <= priv;
        tl        <= tl + tl_t'(1);
      end else begin
        red <= 1'b1;
      end
    end else if (done_go) begin
      if (tl != '0) begin
        priv <= stack[tl_dec];
        tl   <= tl_dec;
      end
    end else if (wr_go) begin
      priv <= wr_priv;
    end
  end

endmodule

// File: rtl/sparc_tlu_pstate_priv.sv
// rtl/sparc_tlu_pstate_priv.sv - TLU PSTATE.PRIV / TL owner: trap handshake, thread decode, error pulses
// TLU_PRIV_WR_CHK_EN blocks unprivileged wrpr attempts to raise PRIV and reports them on priv_viol.
module sparc_tlu_pstate_priv
  import sparc_tlu_priv_pkg::*;
(
  input  logic                   rclk,
  input  logic                   reset,
  input  logic                   trap_vld,
  input  thr_id_t                trap_thr,
  output logic                   trap_ack,
  input  logic                   done_vld,
  input  thr_id_t                done_thr,
  input  logic                   wrpr_vld,
  input  thr_id_t                wrpr_thr,
  input  logic                   wrpr_priv,
  output logic [NUM_THR-1:0]     tlu_lsu_pstate_priv,
  output logic [NUM_THR*TLW-1:0] tlu_tl,
  output logic [NUM_THR-1:0]     red_state,
  output logic                   done_err,
  output logic                   priv_viol
);

  trap_fsm_e          state;
  logic               trap_take;
  logic [NUM_THR-1:0] trap_dec;
  logic [NUM_THR-1:0] done_dec;
  logic [NUM_THR-1:0] wr_dec;
  logic [NUM_THR-1:0] wr_blk;
  logic [NUM_THR-1:0] tl_zero;
  logic               done_err_nxt;
  logic               priv_viol_nxt;

  assign trap_take = (state == IDLE) && trap_vld;

  for (genvar g = 0; g < NUM_THR; g++) begin : g_thr
    assign trap_dec[g] = trap_take && (trap_thr == thr_id_t'(g));
    assign done_dec[g] = done_vld  && (done_thr == thr_id_t'(g));
    assign wr_dec[g]   = wrpr_vld  && (wrpr_thr == thr_id_t'(g));
    assign tl_zero[g]  = (tlu_tl[g*TLW +: TLW] == '0);
`ifdef TLU_PRIV_WR_CHK_EN
    assign wr_blk[g]   = wrpr_priv && !tlu_lsu_pstate_priv[g];
`else
    assign wr_blk[g]   = 1'b0;
`endif

    sparc_tlu_priv_thr u_thr (
      .rclk    (rclk),
      .reset   (reset),
      .trap_go (trap_dec[g]),
      .done_go (done_dec[g]),
      .wr_go   (wr_dec[g] && !wr_blk[g]),
      .wr_priv (wrpr_priv),
      .priv    (tlu_lsu_pstate_priv[g]),
      .tl      (tlu_tl[g*TLW +: TLW]),
      .red     (red_state[g])
    );
  end

  // Pulses only count events that survived same-thread priority.
  assign done_err_nxt  = |(done_dec & ~trap_dec & tl_zero);
  assign priv_viol_nxt = |(wr_dec & wr_blk & ~trap_dec & ~done_dec);

  always_ff @(posedge rclk) begin
    if (reset) begin
      state     <= IDLE;
      trap_ack  <= 1'b0;
      done_err  <= 1'b0;
      priv_viol <= 1'b0;
    end else begin
      done_err  <= done_err_nxt;
      priv_viol <= priv_viol_nxt;
      case (state)
        IDLE: begin
          trap_ack <= trap_vld;
          if (trap_vld) state <= ACK;
        end
        ACK: begin
          trap_ack <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          trap_ack <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sparc_tlu_pstate_priv.sv
// tb/tb_sparc_tlu_pstate_priv.sv - directed and random checks of sparc_tlu_pstate_priv against a queue-based model
// Honours TLU_PRIV_WR_CHK_EN the same way the design does.
module tb_sparc_tlu_pstate_priv;

  logic        rclk = 1'b0;
  logic        reset;
  logic        trap_vld;
  logic [1:0]  trap_thr;
  logic        trap_ack;
  logic        done_vld;
  logic [1:0]  done_thr;
  logic        wrpr_vld;
  logic [1:0]  wrpr_thr;
  logic        wrpr_priv;
  logic [3:0]  tlu_lsu_pstate_priv;
  logic [11:0] tlu_tl;
  logic [3:0]  red_state;
  logic        done_err;
  logic        priv_viol;

  sparc_tlu_pstate_priv dut (
    .rclk                (rclk),
    .reset               (reset),
    .trap_vld            (trap_vld),
    .trap_thr            (trap_thr),
    .trap_ack            (trap_ack),
    .done_vld            (done_vld),
    .done_thr            (done_thr),
    .wrpr_vld            (wrpr_vld),
    .wrpr_thr            (wrpr_thr),
    .wrpr_priv           (wrpr_priv),
    .tlu_lsu_pstate_priv (tlu_lsu_pstate_priv),
    .tlu_tl              (tlu_tl),
    .red_state           (red_state),
    .done_err            (done_err),
    .priv_viol           (priv_viol)
  );

  always #5 rclk = ~rclk;

`ifdef TLU_PRIV_WR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  // Model: each thread's trap level is simply the depth of its saved-PRIV queue.
  bit m_priv [4];
  bit m_red  [4];
  bit stk    [4][$];
  bit m_ack, m_derr, m_viol;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit acc;
    if (reset) begin
      for (int t = 0; t < 4; t++) begin
        m_priv[t] = 1'b1;
        m_red[t]  = 1'b0;
        stk[t].delete();
      end
      m_ack = 0; m_derr = 0; m_viol = 0;
      return;
    end
    acc = trap_vld && !m_ack;
    m_derr = 0;
    m_viol = 0;
    for (int t = 0; t < 4; t++) begin
      if (acc && trap_thr == t) begin
        if (stk[t].size() < 6) stk[t].push_back(m_priv[t]);
        else m_red[t] = 1'b1;
        m_priv[t] = 1'b1;
      end else if (done_vld && done_thr == t) begin
        if (stk[t].size() > 0) m_priv[t] = stk[t].pop_back();
        else m_derr = 1'b1;
      end else if (wrpr_vld && wrpr_thr == t) begin
        if (CHK && wrpr_priv && !m_priv[t]) m_viol = 1'b1;
        else m_priv[t] = wrpr_priv;
      end
    end
    m_ack = acc;
  endtask

  always @(negedge rclk) begin
    logic [3:0]  ep, er;
    logic [11:0] et;
    if (check_en) begin
      for (int t = 0; t < 4; t++) begin
        ep[t] = m_priv[t];
        er[t] = m_red[t];
        et[t*3 +: 3] = 3'(stk[t].size());
      end
      chk("priv", 32'(tlu_lsu_pstate_priv), 32'(ep));
      chk("tl", 32'(tlu_tl), 32'(et));
      chk("red", 32'(red_state), 32'(er));
      chk("trap_ack", 32'(trap_ack), 32'(m_ack));
      chk("done_err", 32'(done_err), 32'(m_derr));
      chk("priv_viol", 32'(priv_viol), 32'(m_viol));
    end
  end

  task automatic cyc(input bit r, input bit tv, input int tt, input bit dv, input int dt,
                     input bit wv, input int wt, input bit wp);
    reset = r; trap_vld = tv; trap_thr = 2'(tt);
    done_vld = dv; done_thr = 2'(dt);
    wrpr_vld = wv; wrpr_thr = 2'(wt); wrpr_priv = wp;
    @(posedge rclk);
    model_step();
    @(negedge rclk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [2:0] tl_of(input int t);
    return tlu_tl[t*3 +: 3];
  endfunction

  initial begin
    int acks;
    bit exp_p;
    reset = 1'b1; trap_vld = 0; trap_thr = 0; done_vld = 0; done_thr = 0;
    wrpr_vld = 0; wrpr_thr = 0; wrpr_priv = 0;

    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check_en = 1'b1;
    chk("lit_reset_priv", 32'(tlu_lsu_pstate_priv), 32'hf);
    chk("lit_reset_tl", 32'(tlu_tl), 32'h0);
    chk("lit_reset_red", 32'(red_state), 32'h0);
    chk("lit_reset_ack", 32'(trap_ack), 32'h0);

    cyc(0, 0, 0, 0, 0, 1, 2, 0);
    chk("lit_wrpr_priv", 32'(tlu_lsu_pstate_priv), 32'hb);

    cyc(0, 1, 2, 0, 0, 0, 0, 0);
    chk("lit_trap_ack", 32'(trap_ack), 32'h1);
    chk("lit_trap_tl2", 32'(tl_of(2)), 32'h1);
    chk("lit_trap_priv2", 32'(tlu_lsu_pstate_priv[2]), 32'h1);
    idle();
    chk("lit_ack_one_cycle", 32'(trap_ack), 32'h0);
    cyc(0, 0, 0, 1, 2, 0, 0, 0);
    chk("lit_done_priv", 32'(tlu_lsu_pstate_priv), 32'hb);
    chk("lit_done_tl2", 32'(tl_of(2)), 32'h0);

    // Alternate PRIV between traps so each stack level holds a distinct value.
    acks = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      acks += int'(trap_ack);
      cyc(0, 0, 0, 0, 0, 1, 1, 1'(i & 1));
    end
    chk("lit_acks", 32'(acks), 32'd7);
    chk("lit_tl1_sat", 32'(tl_of(1)), 32'd6);
    chk("lit_red1", 32'(red_state[1]), 32'h1);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 0, 1, 1, 0, 0, 0);
      exp_p = ((5 - k) == 0) ? 1'b1 : 1'((5 - k - 1) & 1);
      chk("lit_pop_priv1", 32'(tlu_lsu_pstate_priv[1]), 32'(exp_p));
      chk("lit_pop_tl1", 32'(tl_of(1)), 32'(5 - k));
    end
    cyc(0, 0, 0, 1, 1, 0, 0, 0);
    chk("lit_done_err", 32'(done_err), 32'h1);
    chk("lit_done_err_tl1", 32'(tl_of(1)), 32'h0);
    idle();

    cyc(0, 1, 0, 1, 0, 1, 0, 0);
    chk("lit_prio_tl0", 32'(tl_of(0)), 32'h1);
    chk("lit_prio_priv0", 32'(tlu_lsu_pstate_priv[0]), 32'h1);
    chk("lit_prio_no_derr", 32'(done_err), 32'h0);
    idle();
    cyc(0, 1, 3, 1, 0, 1, 1, 0);
    chk("lit_split_tl3", 32'(tl_of(3)), 32'h1);
    chk("lit_split_tl0", 32'(tl_of(0)), 32'h0);
    chk("lit_split_priv1", 32'(tlu_lsu_pstate_priv[1]), 32'h0);
    idle();

    cyc(0, 1, 2, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_rst_ack", 32'(trap_ack), 32'h0);
    chk("lit_rst_priv", 32'(tlu_lsu_pstate_priv), 32'hf);
    chk("lit_rst_tl", 32'(tlu_tl), 32'h0);
    chk("lit_rst_red", 32'(red_state), 32'h0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("lit_rst_trap_ack", 32'(trap_ack), 32'h0);
    chk("lit_rst_trap_tl", 32'(tlu_tl), 32'h0);
    idle();

    cyc(0, 0, 0, 0, 0, 1, 3, 0);
    cyc(0, 0, 0, 0, 0, 1, 3, 1);
    chk("lit_wrchk_priv3", 32'(tlu_lsu_pstate_priv[3]), CHK ? 32'h0 : 32'h1);
    chk("lit_wrchk_viol", 32'(priv_viol), CHK ? 32'h1 : 32'h0);

    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 1) == 0, int'($urandom_range(0, 3)),
          $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
          $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)));
    end
    check_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
